ex_result_stage: RTL



---
 rtl/ex_result_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ex_result_stage.sv
// rtl/ex_result_stage.sv - execute result 2-entry skid buffer and Z/N/V flag register
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream result handshake
//   in_result, in_ovfl, in_opcode, in_dst, in_wr_en   result beat and flag sources
//   flush               drop every buffered result and any beat offered this cycle
//   out_valid/out_ready downstream handshake; out_result/out_dst/out_wr_en head entry
//   flag_z/flag_n/flag_v architectural flags, updated in program order on accept
module ex_result_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_ovfl,
  input  logic [3:0]    in_opcode,
  input  logic [RW-1:0] in_dst,
  input  logic          in_wr_en,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_dst,
  output logic          out_wr_en,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_v
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] main_result, skid_result;
  logic [RW-1:0] main_dst, skid_dst;
  logic          main_wr_en, skid_wr_en;
  logic          accept, drain;
  logic          load_main_in, load_skid_in, skid_to_main;
  logic          upd_z, upd_nv, flag_we;

  // in_ready is a pure state decode so it never combinationally depends on out_ready.
  assign in_ready   = (state != TWO);
  assign out_valid  = (state != EMPTY);
  assign accept     = in_valid & in_ready;
  assign drain      = out_valid & out_ready;
  assign out_result = main_result;
  assign out_dst    = main_dst;
  assign out_wr_en  = main_wr_en;

  always_comb begin
    state_nxt    = state;
    load_main_in = 1'b0;
    load_skid_in = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt    = TWO;
            load_skid_in = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (drain) begin
          state_nxt    = ONE;
          skid_to_main = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Which flags the producing opcode is allowed to touch.
  always_comb begin
    upd_z  = 1'b0;
    upd_nv = 1'b0;
    case (in_opcode)
      4'b0000, 4'b0001: begin
        upd_z  = 1'b1;
        upd_nv = 1'b1;
      end
      4'b0010, 4'b0100, 4'b0101, 4'b0110: upd_z = 1'b1;
      default: ;
    endcase
  end

  // A beat offered alongside flush is dropped, so it must not reach the flags either.
  assign flag_we = accept & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_result <= '0;
      main_dst    <= '0;
      main_wr_en  <= 1'b0;
      skid_result <= '0;
      skid_dst    <= '0;
      skid_wr_en  <= 1'b0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      flag_v      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_result <= in_result;
        main_dst    <= in_dst;
        main_wr_en  <= in_wr_en;
      end else if (skid_to_main) begin
        main_result <= skid_result;
        main_dst    <= skid_dst;
        main_wr_en  <= skid_wr_en;
      end
      if (load_skid_in) begin
        skid_result <= in_result;
        skid_dst    <= in_dst;
        skid_wr_en  <= in_wr_en;
      end
      if (flag_we && upd_z) flag_z <= (in_result == '0);
      if (flag_we && upd_nv) begin
        flag_n <= in_result[DW-1];
        flag_v <= in_ovfl;
      end
    end
  end

endmodule
